input_buffer_ctrl: RTL
======================

# input_buffer_ctrl

Input-side buffer and gearbox for the accelerator datapath. It accepts 64-bit AXI-Stream beats from the DMA MM2S channel and packs each pair of beats, low beat first, into one 128-bit word (16 x INT8). The words go through a synchronous FIFO and are presented to the compute-array loader on a registered valid/ready interface. It is the receive-direction counterpart of the 128→64 output buffer and decouples DMA burst timing from array fetch timing.

## Interface
- DEPTH_LOG2, 8, log2 of FIFO memory depth; DEPTH = 2^DEPTH_LOG2 words of 129 bits (128 data + last)
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- i_clr  in  1  synchronous flush: empties FIFO, output register and gearbox
- s_axis_tdata  in  64  input beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid && tready
- s_axis_tlast  in  1  last beat of packet
- o_data  out  128  packed word, registered
- o_last  out  1  word holds the packet's last beat, registered
- o_valid  out  1  o_data valid, registered
- i_ready  in  1  consumer takes word when o_valid && i_ready
- o_level  out  DEPTH_LOG2+1  words in FIFO memory; excludes output register
- o_full  out  1  o_level == DEPTH
- o_empty  out  1  o_level == 0
- o_odd_flush  out  1  one-cycle pulse: tlast accepted on a low beat

## Operation
- Gearbox FSM, 2 states, reset state S_LOW:
  - S_LOW: an accepted beat with tlast=0 is latched into half_reg[63:0], then the FSM goes to S_HIGH. An accepted beat with tlast=1 writes {64'b0, tdata} with last=1 into the FIFO, pulses o_odd_flush, and the FSM stays in S_LOW.
  - S_HIGH: an accepted beat writes {tdata, half_reg} with last=tlast into the FIFO, then the FSM goes to S_LOW.
- s_axis_tready = rst_n && !i_clr && !o_full. The state does not affect tready.
- FIFO: pointers of DEPTH_LOG2+1 bits; wrap-around on the MSB; full/empty decoded from the registered pointers.
- Output stage (first-word-fall-through register): load from the FIFO when !o_empty && (!o_valid || i_ready). On load, update o_data/o_last, set o_valid=1, increment the read pointer. When o_valid && i_ready and the FIFO is empty, clear o_valid.
- Total storage is DEPTH+1 words.
- Simultaneous FIFO write and read in one cycle: o_level is unchanged. A write while o_full never happens because tready is low.
- i_clr overrides everything in its cycle:
  - pointers go to 0, half_reg is discarded, FSM returns to S_LOW
  - o_valid=0, o_last=0
  - no beat is accepted
- Reset values: s_axis_tready=0 while rst_n=0 and 1 in the first cycle after release. o_data=0, o_last=0, o_valid=0, o_level=0, o_full=0, o_empty=1, o_odd_flush=0.
- Reset or i_clr mid-packet drops any pending low beat. The next accepted beat is treated as a low beat.

## Timing
- Cycle N: high beat (or tlast-on-low beat) accepted; FIFO written at the end of N.
- Cycle N+1: o_empty=0 and o_level reflect the write. If the output register is free, it loads at the end of N+1.
- Cycle N+2: o_valid=1 with the word. Latency is 2 cycles from the accepting edge.
- Sustained input throughput: 1 beat per cycle. Sustained output: 1 word per 2 cycles. The output side can drain 1 word per cycle.
- When full, a consumer read frees a slot: o_level decrements and o_full falls the cycle after the read; tready rises in that same cycle.
- o_odd_flush is asserted in cycle N+1 for an odd flush accepted in cycle N.
- No combinational path from s_axis_tvalid to any output, or from i_ready to s_axis_tready.

## Test plan
- Even packet: i_ready=1; beats A0..A3 = 64'h0..0 through 64'h..03, tlast on A3 → two words, {A1,A0} with o_last=0 then {A3,A2} with o_last=1; first o_valid 2 cycles after the A1 handshake.
- Odd packet: beats B0,B1,B2, tlast on B2 → {B1,B0} with last=0, then {64'b0,B2} with last=1; o_odd_flush is a single-cycle pulse; the next beat is packed as a low beat.
- Fill: i_ready=0, tvalid=1 continuously, DEPTH=256 → exactly 514 beats accepted, then tready=0, o_full=1, o_level=256, o_valid=1; one i_ready cycle → o_level=255 and tready=1 the next cycle, 2 more beats accepted.
- Random backpressure: 4096 beats, tvalid and i_ready each random at 50% → words match the reference model in order, no loss, no duplication; o_level never exceeds 256.
- Mid-packet reset: assert rst_n=0 after one low beat → all outputs at reset values immediately; after release, beats C0,C1 produce {C1,C0}.
- Clear with data queued: 5 words buffered, then i_clr=1 for one cycle → next cycle o_valid=0, o_level=0, o_empty=1, and tready=0 during the clear cycle; subsequent pairing restarts at a low beat.

Source files
------------

// File: rtl/input_buffer_ctrl_if.sv
// rtl/input_buffer_ctrl_if.sv - stream-in / word-out bundle for the input buffer
// The master side is the DMA plus the array loader; the slave side is the buffer.
interface input_buffer_ctrl_if #(
   parameter int DEPTH_LOG2 = 8
);
   logic                  i_clr;
   logic [63:0]           s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic                  s_axis_tlast;
   logic [127:0]          o_data;
   logic                  o_last;
   logic                  o_valid;
   logic                  i_ready;
   logic [DEPTH_LOG2:0]   o_level;
   logic                  o_full;
   logic                  o_empty;
   logic                  o_odd_flush;

   modport master (
      output i_clr, s_axis_tdata, s_axis_tvalid, s_axis_tlast, i_ready,
      input  s_axis_tready, o_data, o_last, o_valid, o_level, o_full, o_empty, o_odd_flush
   );

   modport slave (
      input  i_clr, s_axis_tdata, s_axis_tvalid, s_axis_tlast, i_ready,
      output s_axis_tready, o_data, o_last, o_valid, o_level, o_full, o_empty, o_odd_flush
   );
endinterface

// File: rtl/input_buffer_ctrl.sv
// rtl/input_buffer_ctrl.sv - 64->128 gearbox, word FIFO and registered output stage
// Beat pairs pack low-first into 129-bit entries; the output register adds one word of storage.
module input_buffer_ctrl #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input_buffer_ctrl_if.slave     bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

   typedef enum logic {S_LOW, S_HIGH} state_t;

   state_t                state, state_nxt;
   logic [63:0]           half_reg, half_nxt;
   logic                  accept;
   logic                  wr_en;
   logic                  wr_last;
   logic [127:0]          wr_data;
   logic                  odd_nxt;
   logic                  load;
   logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
   logic [128:0]          mem [DEPTH];

   assign bus.s_axis_tready = rst_n && !bus.i_clr && !bus.o_full;
   assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_LOW;
         half_reg        <= '0;
         bus.o_odd_flush <= 1'b0;
      end else begin
         state           <= state_nxt;
         half_reg        <= half_nxt;
         bus.o_odd_flush <= odd_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      half_nxt  = half_reg;
      wr_en     = 1'b0;
      wr_last   = 1'b0;
      wr_data   = '0;
      odd_nxt   = 1'b0;
      if (bus.i_clr) begin
         state_nxt = S_LOW;
      end else if (accept) begin
         case (state)
            S_LOW: begin
               if (bus.s_axis_tlast) begin
                  wr_en   = 1'b1;
                  wr_last = 1'b1;
                  wr_data = {64'b0, bus.s_axis_tdata};
                  odd_nxt = 1'b1;
               end else begin
                  half_nxt  = bus.s_axis_tdata;
                  state_nxt = S_HIGH;
               end
            end
            S_HIGH: begin
               wr_en     = 1'b1;
               wr_last   = bus.s_axis_tlast;
               wr_data   = {bus.s_axis_tdata, half_reg};
               state_nxt = S_LOW;
            end
            default: state_nxt = S_LOW;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= {wr_last, wr_data};
   end

   // Full and empty come straight from the registered pointers; the extra MSB tells wrap apart.
   assign bus.o_level = wr_ptr - rd_ptr;
   assign bus.o_empty = (wr_ptr == rd_ptr);
   assign bus.o_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                        (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign load        = !bus.o_empty && (!bus.o_valid || bus.i_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (bus.i_clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (load)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.o_data  <= '0;
         bus.o_last  <= 1'b0;
         bus.o_valid <= 1'b0;
      end else if (bus.i_clr) begin
         bus.o_last  <= 1'b0;
         bus.o_valid <= 1'b0;
      end else if (load) begin
         {bus.o_last, bus.o_data} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
         bus.o_valid              <= 1'b1;
      end else if (bus.o_valid && bus.i_ready) begin
         bus.o_valid <= 1'b0;
      end
   end
endmodule
